// File: rtl/branch_resolve_pkg.sv
// Shared types for branch resolution: queued prediction entry, FSM states, PC step.
// Pure declarations; no logic, no latency, no flow control.
package branch_resolve_pkg;

  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

  typedef struct packed {
    word_t pc;
    logic  taken;
    word_t npc;
  } bres_entry_t;

  typedef enum logic {BRES_RUN, BRES_RECOVER} bres_state_t;

  localparam int BRES_PC_INC = 4;

endpackage

// File: rtl/branch_resolve_if.sv
// Fetch push side, EX resolve side and predictor/flush outputs of branch_resolve.
// slave = the resolver, master = the surrounding pipeline.
interface branch_resolve_if #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) ();

  logic                     pred_valid;
  logic [PC_W-1:0]          pred_pc;
  logic                     pred_taken;
  logic [PC_W-1:0]          pred_npc;
  logic                     pred_ready;
  logic                     res_valid;
  logic                     res_taken;
  logic [PC_W-1:0]          res_target;
  logic                     upd_valid;
  logic                     upd_hit;
  logic                     flush;
  logic [PC_W-1:0]          flush_pc;
  logic [$clog2(DEPTH):0]   count;

  modport slave (
    input  pred_valid, pred_pc, pred_taken, pred_npc,
    input  res_valid, res_taken, res_target,
    output pred_ready, upd_valid, upd_hit, flush, flush_pc, count
  );

  modport master (
    output pred_valid, pred_pc, pred_taken, pred_npc,
    output res_valid, res_taken, res_target,
    input  pred_ready, upd_valid, upd_hit, flush, flush_pc, count
  );

endinterface

// File: rtl/branch_resolve_fifo.sv
// In-order circular queue of outstanding predictions; head is visible combinationally.
// Push ignored when full, pop ignored when empty; clear wins over push and pop.
module bres_fifo
  import branch_resolve_pkg::*;
#(
  parameter type T     = bres_entry_t,
  parameter int  DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  T                       push_dat,
  input  logic                   pop,
  input  logic                   clear,
  output T                       head_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/branch_resolve.sv
// Resolves the oldest queued prediction against the EX outcome: predictor update and flush 1 cycle later.
// pred_ready drops when full or while recovering from a mispredict; BRES_STATS_EN adds saturating counters.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  branch_resolve_if.slave   bus
`ifdef BRES_STATS_EN
  ,
  output logic [15:0]       stat_resolved,
  output logic [15:0]       stat_mispred
`endif
);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            taken;
    logic [PC_W-1:0] npc;
  } entry_t;

  bres_state_t            state;
  entry_t                 head;
  entry_t                 push_dat;
  logic                   full;
  logic                   empty;
  logic                   accept;
  logic                   mispred;
  logic                   push;
  logic                   clear;
  logic [PC_W-1:0]        correct_pc;
  logic [$clog2(DEPTH):0] fill;

  assign bus.pred_ready = (state == BRES_RUN) && !full;
  assign bus.count      = fill;

  assign accept     = (state == BRES_RUN) && bus.res_valid && !empty;
  assign mispred    = accept && ((bus.res_taken != head.taken) ||
                                 (bus.res_taken && (bus.res_target != head.npc)));
  assign correct_pc = bus.res_taken ? bus.res_target : head.pc + PC_W'(BRES_PC_INC);

  // A push alongside a mispredict belongs to the squashed path, so drop it.
  assign push     = bus.pred_valid && bus.pred_ready && !mispred;
  assign clear    = mispred || (state == BRES_RECOVER);
  assign push_dat = '{pc: bus.pred_pc, taken: bus.pred_taken, npc: bus.pred_npc};

  bres_fifo #(
    .T     (entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .rst      (RST),
    .push     (push),
    .push_dat (push_dat),
    .pop      (accept),
    .clear    (clear),
    .head_dat (head),
    .full     (full),
    .empty    (empty),
    .count    (fill)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= BRES_RUN;
      bus.upd_valid <= 1'b0;
      bus.upd_hit   <= 1'b0;
      bus.flush     <= 1'b0;
      bus.flush_pc  <= '0;
    end else begin
      bus.upd_valid <= accept;
      bus.flush     <= mispred;
      if (accept)  bus.upd_hit  <= bus.res_taken;
      if (mispred) bus.flush_pc <= correct_pc;
      case (state)
        BRES_RUN:     if (mispred) state <= BRES_RECOVER;
        BRES_RECOVER: state <= BRES_RUN;
        default:      state <= BRES_RUN;
      endcase
    end
  end

`ifdef BRES_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_resolved <= '0;
      stat_mispred  <= '0;
    end else begin
      if (accept && (stat_resolved != 16'hFFFF))  stat_resolved <= stat_resolved + 16'd1;
      if (mispred && (stat_mispred != 16'hFFFF))  stat_mispred  <= stat_mispred + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: directed cases then random traffic against a queue model.
module tb_branch_resolve;
  import branch_resolve_pkg::*;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_resolve_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bus ();

`ifdef BRES_STATS_EN
  logic [15:0] stat_resolved;
  logic [15:0] stat_mispred;
`endif

  branch_resolve #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
`ifdef BRES_STATS_EN
    ,
    .stat_resolved (stat_resolved),
    .stat_mispred  (stat_mispred)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] npc;
  } ent_t;

  typedef struct {
    int          due;
    logic        hit;
    logic        fl;
    logic [31:0] fpc;
  } exp_t;

  ent_t        mq[$];
  exp_t        sb[$];
  bit          m_recover = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  bit          chk_en = 0;
  bit          mon_en = 0;
  bit          done = 0;
  int unsigned m_res = 0;
  int unsigned m_mis = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle, an update is expected exactly when the scoreboard head is due.
  initial begin
    exp_t e;
    bit   want;
    while (!done) begin
      @(negedge clk);
      if (mon_en && !done) begin
        want = (sb.size() > 0) && (sb[0].due == cyc);
        chk("upd_valid", {63'd0, bus.upd_valid}, {63'd0, want});
        if (want) begin
          e = sb.pop_front();
          chk("upd_hit", {63'd0, bus.upd_hit}, {63'd0, e.hit});
          chk("flush", {63'd0, bus.flush}, {63'd0, e.fl});
          if (e.fl) chk("flush_pc", {32'd0, bus.flush_pc}, {32'd0, e.fpc});
        end else begin
          chk("flush_idle", {63'd0, bus.flush}, 64'd0);
        end
      end
    end
  end

  // One clock of stimulus: check visible state, drive inputs, advance the model.
  task automatic step(input bit r, input bit pv, input logic [31:0] ppc, input bit pt,
                      input logic [31:0] pnpc, input bit rv, input bit rt, input logic [31:0] rtar);
    ent_t h;
    exp_t e;
    bit   ready;
    bit   mis;
    @(negedge clk);
    if (chk_en) begin
      chk("count", {61'd0, bus.count}, 64'(mq.size()));
      chk("pred_ready", {63'd0, bus.pred_ready}, {63'd0, (!m_recover && mq.size() < DEPTH)});
    end
    #1;
    rst            = r;
    bus.pred_valid = pv;
    bus.pred_pc    = ppc;
    bus.pred_taken = pt;
    bus.pred_npc   = pnpc;
    bus.res_valid  = rv;
    bus.res_taken  = rt;
    bus.res_target = rtar;
    mis = 0;
    if (r) begin
      mq.delete();
      m_recover = 0;
      m_res = 0;
      m_mis = 0;
    end else if (m_recover) begin
      m_recover = 0;
    end else begin
      ready = (mq.size() < DEPTH);
      if (rv && mq.size() > 0) begin
        h = mq.pop_front();
        mis = (rt != h.taken) || (rt && rtar != h.npc);
        e.due = cyc + 1;
        e.hit = rt;
        e.fl  = mis;
        e.fpc = rt ? rtar : h.pc + 32'd4;
        sb.push_back(e);
        if (m_res < 65535) m_res++;
        if (mis) begin
          mq.delete();
          m_recover = 1;
          if (m_mis < 65535) m_mis++;
        end
      end
      if (pv && ready && !mis) begin
        h.pc = ppc; h.taken = pt; h.npc = pnpc;
        mq.push_back(h);
      end
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push(input logic [31:0] pc, input bit t, input logic [31:0] npc);
    step(0, 1, pc, t, npc, 0, 0, 0);
  endtask

  task automatic resolve(input bit t, input logic [31:0] tar);
    step(0, 0, 0, 0, 0, 1, t, tar);
  endtask

  initial begin
    logic [31:0] ppc, pnpc, rtar;
    bit          pv, pt, rv, rt;

    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_upd_valid", {63'd0, bus.upd_valid}, 64'd0);
    chk("rst_upd_hit", {63'd0, bus.upd_hit}, 64'd0);
    chk("rst_flush", {63'd0, bus.flush}, 64'd0);
    chk("rst_flush_pc", {32'd0, bus.flush_pc}, 64'd0);
    chk_en = 1;
    mon_en = 1;

    // Correct not-taken prediction.
    push(32'h100, 0, 32'h104);
    resolve(0, 32'h0);
    idle();

    // Fill to DEPTH starting at pointer 1, refused 5th push alongside a pop, drain across the wrap.
    push(32'h1000, 0, 32'h1004);
    push(32'h2000, 1, 32'h2400);
    push(32'h3000, 0, 32'h3004);
    push(32'h4000, 1, 32'h4800);
    step(0, 1, 32'h5000, 0, 32'h5004, 1, 0, 32'h0);
    resolve(1, 32'h2400);
    resolve(0, 32'h0);
    resolve(1, 32'h4800);
    idle();

    // Direction mispredict, then target mispredict, then pc+4 wrap.
    push(32'h200, 0, 32'h204);
    resolve(1, 32'h300);
    idle(); idle();
    push(32'h400, 1, 32'h500);
    resolve(1, 32'h540);
    idle(); idle();
    push(32'hFFFF_FFFC, 1, 32'h600);
    resolve(0, 32'h0);
    idle(); idle();

    // Push alongside a mispredicting resolve is squashed.
    push(32'h700, 0, 32'h704);
    step(0, 1, 32'h800, 0, 32'h804, 1, 1, 32'h900);
    idle(); idle();

    // Resolve on an empty queue is ignored.
    resolve(1, 32'h1234);
    idle();

    // Reset with entries queued.
    push(32'hA00, 0, 32'hA04);
    push(32'hB00, 0, 32'hB04);
    push(32'hC00, 0, 32'hC04);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle();

    for (int i = 0; i < 1500; i++) begin
      pv   = ($urandom_range(0, 9) < 6);
      pt   = $urandom_range(0, 1) == 1;
      ppc  = {$urandom_range(0, 255), 2'b00} | ($urandom_range(0, 15) == 0 ? 32'hFFFF_FF00 : 32'h0);
      pnpc = pt ? {$urandom_range(0, 1023), 2'b00} : ppc + 32'd4;
      rv   = ($urandom_range(0, 9) < 5);
      rt   = $urandom_range(0, 1) == 1;
      rtar = {$urandom_range(0, 1023), 2'b00};
      if (mq.size() > 0 && $urandom_range(0, 9) < 7) begin
        rt   = mq[0].taken;
        rtar = mq[0].npc;
      end
      step(($urandom_range(0, 299) == 0), pv, ppc, pt, pnpc, rv, rt, rtar);
    end

    idle(); idle(); idle();
`ifdef BRES_STATS_EN
    @(negedge clk);
    chk("stat_resolved", {48'd0, stat_resolved}, 64'(m_res));
    chk("stat_mispred", {48'd0, stat_mispred}, 64'(m_mis));
`endif
    done = 1;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
